decimate_avg: RTL and testbench



---
 rtl/decimate_avg.sv | 95 +++++++++
 tb/tb_decimate_avg.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/decimate_avg.sv
// decimate_avg: averages each non-overlapping window of 2**log2_decim_p
// accepted signed samples and emits one result per window over valid/ready.
// Optional macro DECIMATE_AVG_ROUND_EN: round half toward +inf with clamp to
// max positive; when undefined the result is a plain floor (arithmetic shift).
// Ports:
//   clk_i    clock, rising edge
//   reset_i  synchronous active-high reset
//   valid_i  upstream sample valid
//   data_i   upstream sample (signed, width_p)
//   ready_o  block can accept data_i (combinational from ready_i)
//   valid_o  averaged result valid
//   data_o   averaged result (signed, width_p)
//   ready_i  downstream can accept data_o
module decimate_avg #(
  parameter int unsigned width_p      = 10,
  parameter int unsigned log2_decim_p = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      valid_i,
  input  logic signed [width_p-1:0] data_i,
  output logic                      ready_o,
  output logic                      valid_o,
  output logic signed [width_p-1:0] data_o,
  input  logic                      ready_i
);

  localparam int unsigned acc_w = width_p + log2_decim_p;
  // Keep the counter at least one bit wide so N = 1 still elaborates.
  localparam int unsigned cnt_w = (log2_decim_p == 0) ? 1 : log2_decim_p;
  localparam logic [cnt_w-1:0] last_cnt = cnt_w'((1 << log2_decim_p) - 1);

  logic signed [acc_w-1:0]   acc_q;
  logic        [cnt_w-1:0]   cnt_q;
  logic signed [acc_w-1:0]   sum;
  logic signed [width_p-1:0] result;
  logic                      is_final;
  logic                      accept;

  assign is_final = (cnt_q == last_cnt);
  assign ready_o  = ~is_final | ~valid_o | ready_i;
  assign accept   = valid_i & ready_o;
  assign sum      = acc_q + acc_w'(data_i);

`ifdef DECIMATE_AVG_ROUND_EN
  localparam logic signed [acc_w:0] rnd_add =
    (acc_w+1)'((log2_decim_p == 0) ? 0 : (1 << (log2_decim_p - 1)));
  localparam logic signed [acc_w:0] max_pos =
    (acc_w+1)'((1 << (width_p - 1)) - 1);

  logic signed [acc_w:0] rnd_sum;
  logic signed [acc_w:0] rnd_shift;

  // Extra headroom bit so the rounding add cannot wrap; only the top can overflow.
  always_comb begin
    rnd_sum   = (acc_w+1)'(sum) + rnd_add;
    rnd_shift = rnd_sum >>> log2_decim_p;
    result    = (rnd_shift > max_pos) ? width_p'(max_pos) : width_p'(rnd_shift);
  end
`else
  logic signed [acc_w-1:0] flr_shift;

  // Floor average; the shifted sum always fits back in width_p bits.
  always_comb begin
    flr_shift = sum >>> log2_decim_p;
    result    = width_p'(flr_shift);
  end
`endif

  // Window accumulation and output register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      if (valid_o & ready_i) begin
        valid_o <= 1'b0;
      end
      if (accept) begin
        if (is_final) begin
          data_o  <= result;
          valid_o <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_q + cnt_w'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decimate_avg.sv
// tb_decimate_avg: directed self-checking bench for decimate_avg (N = 4, width 10).
module tb_decimate_avg;

  localparam int unsigned W  = 10;
  localparam int unsigned L2 = 2;

  logic                clk_i;
  logic                reset_i;
  logic                valid_i;
  logic signed [W-1:0] data_i;
  logic                ready_o;
  logic                valid_o;
  logic signed [W-1:0] data_o;
  logic                ready_i;

  int checks;
  int errors;

  decimate_avg #(.width_p(W), .log2_decim_p(L2)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .ready_i (ready_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one sample and hold it until accepted (bounded wait).
  task automatic push(input int v);
    int n;
    valid_i = 1'b1;
    data_i  = W'(v);
    n = 0;
    while (!ready_o && n < 50) begin
      step();
      n++;
    end
    if (!ready_o) check("push_timeout", int'(ready_o), 1);
    step();
    valid_i = 1'b0;
  endtask

  function automatic int ref_avg(input int s);
    int r;
`ifdef DECIMATE_AVG_ROUND_EN
    r = (s + 2) >>> 2;
    if (r > 511) r = 511;
`else
    r = s >>> 2;
`endif
    return r;
  endfunction

  int samp [64];
  int wsum;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_i = 1'b1;
    valid_i = 1'b0;
    data_i  = '0;
    ready_i = 1'b1;
    step();
    step();
    check("rst_valid", int'(valid_o), 0);
    check("rst_data", int'(data_o), 0);
    check("rst_ready", int'(ready_o), 1);
    reset_i = 1'b0;
    step();

    // Basic window average.
    push(10); push(20); push(30);
    check("win_no_early", int'(valid_o), 0);
    push(40);
    check("win_valid", int'(valid_o), 1);
    check("win_data", int'(data_o), 25);
    step();
    check("win_one_cycle", int'(valid_o), 0);

    // Negative window: floor vs round.
    push(-1); push(-2); push(-3); push(-4);
    check("neg_valid", int'(valid_o), 1);
`ifdef DECIMATE_AVG_ROUND_EN
    check("neg_data", int'(data_o), -2);
`else
    check("neg_data", int'(data_o), -3);
`endif
    push(1); push(2); push(3); push(4);
`ifdef DECIMATE_AVG_ROUND_EN
    check("pos_round", int'(data_o), 3);
`else
    check("pos_floor", int'(data_o), 2);
`endif
    step();

    // Backpressure on the final sample.
    ready_i = 1'b0;
    push(10); push(20); push(30); push(40);
    check("bp_first", int'(data_o), 25);
    push(8); push(8); push(8);
    valid_i = 1'b1;
    data_i  = W'(8);
    check("bp_stall", int'(ready_o), 0);
    step();
    step();
    check("bp_hold_valid", int'(valid_o), 1);
    check("bp_hold_data", int'(data_o), 25);
    check("bp_still_stall", int'(ready_o), 0);
    ready_i = 1'b1;
    #1;
    check("bp_release", int'(ready_o), 1);
    step();
    valid_i = 1'b0;
    check("bp_reload_valid", int'(valid_o), 1);
    check("bp_reload_data", int'(data_o), 8);
    step();
    check("bp_drain", int'(valid_o), 0);

    // Extremes.
    push(511); push(511); push(511); push(511);
    check("max_data", int'(data_o), 511);
    push(-512); push(-512); push(-512); push(-512);
    check("min_data", int'(data_o), -512);
    step();

    // Reset mid-window discards the partial sum.
    push(100); push(100);
    reset_i = 1'b1;
    step();
    check("mid_rst_valid", int'(valid_o), 0);
    reset_i = 1'b0;
    push(8); push(8); push(8);
    check("post_rst_quiet", int'(valid_o), 0);
    push(8);
    check("post_rst_valid", int'(valid_o), 1);
    check("post_rst_data", int'(data_o), 8);
    step();

    // Streaming: continuous valid, 16 results at 4-cycle spacing.
    for (int i = 0; i < 64; i++) samp[i] = ((i * 37 + 5) % 1024) - 512;
    wsum = 0;
    for (int i = 0; i < 64; i++) begin
      valid_i = 1'b1;
      data_i  = W'(samp[i]);
      #1;
      check("st_ready", int'(ready_o), 1);
      wsum += samp[i];
      step();
      check("st_valid", int'(valid_o), (i % 4 == 3) ? 1 : 0);
      if (i % 4 == 3) begin
        check("st_data", int'(data_o), ref_avg(wsum));
        wsum = 0;
      end
    end
    valid_i = 1'b0;
    step();
    check("st_drain", int'(valid_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
